// File: rtl/accum8_if.sv
// ============================================================================
// Module : accum8_if
// Brief  : Operand-in / result-out valid-ready bundle for the accum8 block.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface accum8_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_carry;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_carry
    );

    // The accumulator itself.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_carry
    );
endinterface

`default_nettype wire

// File: rtl/accum8.sv
// ============================================================================
// Module : accum8 (with adder8)
// Brief  : Accumulates NUM_OPS bytes through an 8-bit ripple-carry adder and
//          presents the total plus a sticky carry. Optional macro
//          ACCUM8_SATURATE_EN clamps the total to 0xFF on carry-out.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum_out,
    output logic       c_out
);
    logic [8:0] carry;

    assign carry[0] = 1'b0;

    generate
        for (genvar i = 0; i < 8; i++) begin : g_bit
            assign sum_out[i]  = a[i] ^ b[i] ^ carry[i];
            assign carry[i+1]  = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign c_out = carry[8];
endmodule

module accum8 #(
    parameter int NUM_OPS = 4
) (
    input  logic         clk,
    input  logic         reset,
    accum8_if.slave      bus
);
    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(NUM_OPS - 1);

    state_t     state_q, state_d;
    logic [7:0] acc_q,   acc_d;
    logic       carry_q, carry_d;
    logic [3:0] cnt_q,   cnt_d;

    logic [7:0] sum_out;
    logic       c_out;
    logic [7:0] acc_next;

    adder8 u_adder8 (
        .a       (acc_q),
        .b       (bus.in_data),
        .sum_out (sum_out),
        .c_out   (c_out)
    );

`ifdef ACCUM8_SATURATE_EN
    // Once clamped at 0xFF any further non-zero operand carries out again,
    // so the total stays pinned for the rest of the group.
    assign acc_next = c_out ? 8'hFF : sum_out;
`else
    assign acc_next = sum_out;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ACC: begin
                if (bus.in_valid) begin
                    acc_d   = acc_next;
                    carry_d = carry_q | c_out;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = 4'd0;
                        state_d = ST_OUT;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    acc_d   = 8'd0;
                    carry_d = 1'b0;
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ACC;
            acc_q   <= 8'd0;
            carry_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs decode registered state only.
    assign bus.in_ready  = (state_q == ST_ACC);
    assign bus.out_valid = (state_q == ST_OUT);
    assign bus.out_sum   = acc_q;
    assign bus.out_carry = carry_q;
endmodule

`default_nettype wire

// File: tb/tb_accum8.sv
// ============================================================================
// Module : tb_accum8
// Brief  : Directed self-checking bench for accum8 (NUM_OPS=4 and NUM_OPS=1).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_accum8;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    accum8_if ifc ();
    accum8_if ifc1 ();

    accum8 #(.NUM_OPS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    accum8 #(.NUM_OPS(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1; the operand is accepted on the edge inside.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        while (!ifc.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [7:0] exp_sum, input logic exp_carry);
        int n;
        n = 0;
        while (!ifc.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_valid"}, 32'(ifc.out_valid), 32'd1);
        check({tag, "_sum"},   32'(ifc.out_sum),   32'(exp_sum));
        check({tag, "_carry"}, 32'(ifc.out_carry), 32'(exp_carry));
        check({tag, "_bubble"}, 32'(ifc.in_ready), 32'd0);
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
        check({tag, "_rdy_after"}, 32'(ifc.in_ready),  32'd1);
        check({tag, "_vld_after"}, 32'(ifc.out_valid), 32'd0);
        check({tag, "_acc_clr"},   32'(ifc.out_sum),   32'd0);
        check({tag, "_cf_clr"},    32'(ifc.out_carry), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        ifc.in_valid   = 1'b0;
        ifc.in_data    = 8'd0;
        ifc.out_ready  = 1'b0;
        ifc1.in_valid  = 1'b0;
        ifc1.in_data   = 8'd0;
        ifc1.out_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        check("rst_in_ready",  32'(ifc.in_ready),  32'd1);
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_out_sum",   32'(ifc.out_sum),   32'd0);
        check("rst_out_carry", 32'(ifc.out_carry), 32'd0);

        // Back-to-back 10,20,30,40.
        send(8'd10); send(8'd20); send(8'd30);
        check("g1_not_yet", 32'(ifc.out_valid), 32'd0);
        send(8'd40);
        check("g1_latency", 32'(ifc.out_valid), 32'd1);
        recv("g1", 8'h64, 1'b0);

        // Overflow group.
        send(8'h80); send(8'h80); send(8'h01); send(8'h02);
`ifdef ACCUM8_SATURATE_EN
        recv("ovf", 8'hFF, 1'b1);
`else
        recv("ovf", 8'h03, 1'b1);
`endif

        // Stall the result while hammering the input.
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        ifc.in_valid = 1'b1;
        ifc.in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(ifc.out_valid), 32'd1);
            check("hold_sum",   32'(ifc.out_sum),   32'h0A);
            check("hold_carry", 32'(ifc.out_carry), 32'd0);
            check("hold_rdy",   32'(ifc.in_ready),  32'd0);
        end
        ifc.in_valid = 1'b0;
        recv("hold", 8'h0A, 1'b0);

        // Asynchronous reset mid-group.
        send(8'h11); send(8'h22);
        #2 reset = 1'b1;
        #1;
        check("arst_in_ready",  32'(ifc.in_ready),  32'd1);
        check("arst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("arst_out_sum",   32'(ifc.out_sum),   32'd0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        send(8'd1); send(8'd1); send(8'd1);
        check("arst_cnt_clr", 32'(ifc.out_valid), 32'd0);
        send(8'd1);
        recv("arst", 8'h04, 1'b0);

        // Gaps between operands.
        send(8'd5);
        repeat (2) begin @(posedge clk); #1; end
        send(8'd6);
        repeat (2) begin @(posedge clk); #1; end
        send(8'd7);
        repeat (2) begin @(posedge clk); #1; end
        check("gap_no_early", 32'(ifc.out_valid), 32'd0);
        send(8'd8);
        recv("gap", 8'h1A, 1'b0);

        // Streaming with out_ready held high.
        ifc.out_ready = 1'b1;
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        check("s1_valid", 32'(ifc.out_valid), 32'd1);
        check("s1_sum",   32'(ifc.out_sum),   32'h0A);
        check("s1_rdy",   32'(ifc.in_ready),  32'd0);
        @(posedge clk); #1;
        check("s1_bubble_rdy", 32'(ifc.in_ready),  32'd1);
        check("s1_bubble_vld", 32'(ifc.out_valid), 32'd0);
        check("s2_start_acc",  32'(ifc.out_sum),   32'd0);
        send(8'hFF); send(8'h01); send(8'h00); send(8'h00);
        check("s2_valid", 32'(ifc.out_valid), 32'd1);
`ifdef ACCUM8_SATURATE_EN
        check("s2_sum",   32'(ifc.out_sum),   32'hFF);
`else
        check("s2_sum",   32'(ifc.out_sum),   32'h00);
`endif
        check("s2_carry", 32'(ifc.out_carry), 32'd1);
        @(posedge clk); #1;
        check("s2_bubble_rdy", 32'(ifc.in_ready),  32'd1);
        check("s2_bubble_vld", 32'(ifc.out_valid), 32'd0);
        check("s2_cf_clr",     32'(ifc.out_carry), 32'd0);
        ifc.out_ready = 1'b0;

        // NUM_OPS=1: each operand is a complete group.
        ifc1.in_valid = 1'b1;
        ifc1.in_data  = 8'hC8;
        @(posedge clk); #1;
        ifc1.in_valid = 1'b0;
        check("one_valid", 32'(ifc1.out_valid), 32'd1);
        check("one_sum",   32'(ifc1.out_sum),   32'hC8);
        check("one_carry", 32'(ifc1.out_carry), 32'd0);
        check("one_rdy",   32'(ifc1.in_ready),  32'd0);
        ifc1.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc1.out_ready = 1'b0;
        check("one_done", 32'(ifc1.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
